lsu: RTL
========

# lsu

Load/store unit between the RV32 execute stage and the word-addressed, single-port data RAM. Accepts one byte/half/word load or store at a time and issues word-aligned accesses to the RAM, which has 1-cycle read latency and no byte enables. Sub-word stores are done as read-modify-write. Load data is sign- or zero-extended.

## Interface
- `ADDR_W`, 32: request/RAM byte-address width.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; the request is accepted on an edge where `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU); ignored for stores and word loads.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `rsp_valid` out 1: one-cycle completion pulse, no backpressure.
- `rsp_rdata` out 32: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: misaligned or illegal-size request.
- `ram_we` out 1: RAM write strobe.
- `ram_addr` out ADDR_W: byte address with bits [1:0] forced to 0.
- `ram_wdata` out 32: full word written to RAM.
- `ram_rdata` in 32: RAM read data, valid one cycle after a read cycle (a cycle with `ram_we`=0).

## Operation
- Request fields are captured on accept. `ram_addr`/`ram_wdata` are driven from captured registers. `ram_we` is decoded from state only.
- States:
  - **IDLE**: `req_ready`=1, `ram_we`=0. On accept, go to ACCESS.
  - **ACCESS**:
    - fault: no RAM activity, go to RESP.
    - word store: `ram_we`=1, `ram_wdata`=captured wdata, go to RESP.
    - otherwise: read cycle (`ram_we`=0), go to RDATA.
  - **RDATA**: `ram_rdata` is valid.
    - load: register the extracted value, go to RESP.
    - sub-word store: register the merged word, go to WRITE.
  - **WRITE**: `ram_we`=1, `ram_wdata`=merged word, go to RESP.
  - **RESP**: `rsp_valid`=1 for exactly one cycle, go to IDLE.
- Lane select is `a=addr[1:0]`.
  - byte = rdata[8a+7:8a]
  - half = rdata[16·a[1]+15:16·a[1]]
  - Sign-extend from bit 7 or 15 unless `req_unsigned`.
- Store merge replaces only the addressed byte/half with `req_wdata[7:0]` or `req_wdata[15:0]`. All other bytes keep their `ram_rdata` value.
- Fault conditions: size 11; half with a[0]=1; word with a≠00. A faulted request never asserts `ram_we`.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.

## Timing
- Cycle 0 is the accept edge. `rsp_valid` is high in cycle:
  - 2 for a word store or a fault
  - 3 for a load
  - 4 for a sub-word store
- Next accept is possible the cycle after RESP. Peak rate is 1 request per 3–5 cycles.
- `req_valid` arriving outside IDLE is ignored; the requester holds it.
- `ram_we` is high for exactly one cycle per store, and zero cycles for loads and faults.
- Reset mid-operation forces IDLE asynchronously, and `ram_we` drops immediately. If reset lands in ACCESS/RDATA of a read-modify-write, the RAM word is left unmodified. No response is produced for the aborted request.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: fault detection as above.
- Not defined:
  - `rsp_fault` is tied to 0.
  - Misaligned halves use lane a[1], and misaligned words use the aligned word; the access proceeds normally.
  - Size 11 is treated as word.

## Structure
- `lsu_pkg`: size encodings (`SZ_B`, `SZ_H`, `SZ_W`) and the state enum.
- Sub-module `lsu_lane_align`: combinational extract/extend and store merge, from (size, a, unsigned, rdata, wdata).

## Test plan
All tests preload word 0x100 = 0x8899AABB.
- LB 0x101 → `rsp_rdata`=0xFFFFFFAA in cycle 3. LBU 0x101 → 0x000000AA.
- LH 0x102 → 0xFFFF8899. LHU 0x102 → 0x00008899.
- SB 0x103, wdata 0x12345677 → a single `ram_we` cycle in WRITE with `ram_wdata`=0x7799AABB. A following LW 0x100 returns 0x7799AABB.
- SW 0x104, wdata 0xDEADBEEF → `ram_we` in cycle 1 and `rsp_valid` in cycle 2. LW 0x104 then returns 0xDEADBEEF.
- LW 0x102 with macro → `rsp_fault`=1 in cycle 2, `rsp_rdata`=0, no RAM write. Without macro → returns 0x8899AABB in cycle 3.
- SH 0x100 with `rst_n` pulsed low in RDATA → `ram_we` never asserted, no `rsp_valid`, `req_ready`=1 after release, word still 0x8899AABB.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RDATA,
    ST_WRITE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extracts/extends load data and merges sub-word store data into a RAM word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  a,
  input  logic        uns,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [4:0]  b_sh;
  logic [4:0]  h_sh;
  logic [31:0] b_lane;
  logic [31:0] h_lane;

  assign b_sh   = {a, 3'b000};
  assign h_sh   = {a[1], 4'b0000};
  assign b_lane = rdata >> b_sh;
  assign h_lane = rdata >> h_sh;

  always_comb begin
    ld_data = rdata;
    st_data = wdata;
    case (size)
      SZ_B: begin
        ld_data = {{24{~uns & b_lane[7]}}, b_lane[7:0]};
        st_data = (rdata & ~(32'h0000_00FF << b_sh)) | ({24'b0, wdata[7:0]} << b_sh);
      end
      SZ_H: begin
        ld_data = {{16{~uns & h_lane[15]}}, h_lane[15:0]};
        st_data = (rdata & ~(32'h0000_FFFF << h_sh)) | ({16'b0, wdata[15:0]} << h_sh);
      end
      default: begin
        ld_data = rdata;
        st_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32 load/store unit driving a word-addressed single-port RAM; sub-word stores use read-modify-write.
// Alignment/illegal-size faults are detected only when LSU_ALIGN_CHECK_EN is defined.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic              fault_q, fault_d;
  logic [1:0]        size_in;
  logic              fault_in;
  logic              accept;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;

  assign accept = req_valid & req_ready;

`ifdef LSU_ALIGN_CHECK_EN
  assign size_in  = req_size;
  assign fault_in = (req_size == 2'b11) ||
                    ((req_size == SZ_H) && req_addr[0]) ||
                    ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  // Without checking, the illegal encoding degrades to a plain word access.
  assign size_in  = (req_size == 2'b11) ? SZ_W : req_size;
  assign fault_in = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .size    (size_q),
    .a       (addr_q[1:0]),
    .uns     (uns_q),
    .rdata   (ram_rdata),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          size_d  = size_in;
          uns_d   = req_unsigned;
          we_d    = req_we;
          fault_d = fault_in;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (fault_q || (we_q && (size_q == SZ_W))) state_d = ST_RESP;
        else                                      state_d = ST_RDATA;
      end
      ST_RDATA: begin
        // wdata_q is reused to hold the merged word for the write-back cycle.
        if (we_q) begin
          wdata_d = st_data;
          state_d = ST_WRITE;
        end else begin
          rdata_d = ld_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_fault = rsp_valid & fault_q;
  assign rsp_rdata = rdata_q;
  assign ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign ram_wdata = wdata_q;
  assign ram_we    = (state_q == ST_WRITE) ||
                     ((state_q == ST_ACCESS) && we_q && !fault_q && (size_q == SZ_W));

endmodule
